bus_transfer_sequencer: RTL
===========================

# bus_transfer_sequencer

Sequencer for register-to-register transfers over the shared tri-state buses 1 and 2. It is the controller and reader on the other end of the tri-state output register bank. For each accepted transfer it raises one-hot output enables for the source registers and a one-hot load strobe for the destination register. It also captures the bus values into its own read-data registers. It sits between the control unit, which issues requests, and the register bank, whose `enable1`/`enable2`/`load` inputs it drives.

## Interface
- `WIDTH`, 8, bus and data width
- `NREGS`, 4, number of registers on the buses (2..16)
- `SELW`, 2, select width; must equal clog2(NREGS)

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `req`  in  1  transfer request; accepted on a rising edge where `ready`=1
- `ready`  out  1  high in IDLE only
- `src1`  in  SELW  register to drive bus1
- `src2`  in  SELW  register to drive bus2
- `use2`  in  1  also drive bus2 from `src2`
- `dst`  in  SELW  destination register; loads from bus1
- `dst_en`  in  1  perform the load; 0 means a read-only transfer
- `bus1`, `bus2`  in  WIDTH  shared buses, sampled
- `enable1`, `enable2`  out  NREGS  one-hot or zero output enables
- `load`  out  NREGS  one-hot or zero load strobe
- `rdata1`, `rdata2`  out  WIDTH  captured bus values
- `done`  out  1  one-cycle pulse when a transfer completes
- `err`  out  1  one-cycle pulse when a request is rejected

## Operation
- On acceptance, `src1`, `src2`, `use2`, `dst` and `dst_en` are latched. Inputs are ignored outside acceptance.
- States:
  - IDLE: `ready`=1; all enables and loads are 0.
  - DRIVE: `enable1`[src1]=1, plus `enable2`[src2]=1 if `use2`. The bus settles.
  - CAPTURE: same enables as DRIVE, plus `load`[dst]=1 if `dst_en`. At the end of this cycle `rdata1`←`bus1`, and `rdata2`←`bus2` if `use2`; otherwise `rdata2` holds.
  - GAP (only with the macro): all enables 0.
- Transitions:
  - IDLE→DRIVE on valid `req`.
  - DRIVE→CAPTURE unconditionally.
  - CAPTURE→GAP→IDLE with the macro; CAPTURE→IDLE without it.
- Validation: a request with any used select ≥ NREGS is invalid. Used selects are `src1`, `src2` if `use2`, and `dst` if `dst_en`. An invalid request:
  - pulses `err` for one cycle after the acceptance edge;
  - stays in IDLE and drives no enables;
  - leaves `rdata*` unchanged.
- `src1`==`src2` with `use2`: legal; the same register drives both buses.
- `dst`==`src1`: legal; the register reloads its own value.
- `done` pulses for one cycle, in the cycle after CAPTURE.
- `enable1`, `enable2` and `load` are registered outputs decoded from latched state. They never glitch and never have more than one bit high per vector.

## Timing
- Reset values: `ready`=1; `enable1`, `enable2`, `load`=0; `rdata1`, `rdata2`=0; `done`, `err`=0; state IDLE.
- Reset asserted mid-transfer: all outputs are forced to reset values immediately (asynchronous). The in-flight transfer is dropped and `done` is not pulsed.
- Let edge 0 be the acceptance edge.
  - DRIVE occupies cycle 1 and CAPTURE cycle 2.
  - `rdata*` are valid after edge 2.
  - `done`=1 in cycle 3.
- Throughput: with the macro, one transfer per 4 cycles, and `ready` returns in cycle 4. Without it, one transfer per 3 cycles, and `ready`=1 in cycle 3 alongside `done`.
- `req` held high in IDLE issues back-to-back transfers; each acceptance edge counts once.

## Configuration
- `BUS_TURNAROUND_EN` defined: the GAP state is inserted. Every transfer is followed by one cycle with all enables 0, giving a break-before-make dead cycle between drivers.
- `BUS_TURNAROUND_EN` undefined: there is no GAP state. A following transfer's DRIVE may start one cycle after CAPTURE. All enables are still low during the intervening IDLE cycle.

## Structure
- Shared package `bus_pkg`:
  - state encoding constants IDLE, DRIVE, CAPTURE, GAP;
  - clog2 helper used to check `SELW`.
- One sub-module, `onehot_decoder` (parameters SELW, NREGS, inputs `sel`/`en`, output one-hot vector). It is instantiated three times, for `enable1`, `enable2` and `load`.

## Test plan
- Reset, then `req` with src1=2, dst=1, dst_en=1, use2=0 and bus1=8'hA5:
  - `enable1`=4'b0100 in cycles 1–2;
  - `load`=4'b0010 in cycle 2 only;
  - `rdata1`=8'hA5 after edge 2;
  - `done` in cycle 3.
- `use2`=1, src1=0, src2=3, bus1=8'h11, bus2=8'h22, dst_en=0:
  - `enable1`=0001 and `enable2`=1000 in cycles 1–2;
  - `load` stays 0;
  - `rdata1`=8'h11 and `rdata2`=8'h22.
- NREGS=3, `req` with dst=3, dst_en=1 → `err` pulse in cycle 1, no enables, `ready` stays 1, `rdata` unchanged.
- `req` held high for 3 transfers → acceptance every 4 cycles with `BUS_TURNAROUND_EN`, every 3 without. Enables are 0 in every GAP/IDLE cycle.
- Assert `reset` during CAPTURE → `enable*`/`load` drop to 0 immediately with no clock edge, `done` never pulses, and `ready`=1.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_pkg                                                            |
// | Shared state encoding and helpers for the bus transfer sequencer.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        GAP     = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | onehot_decoder                                                     |
// | Binary select to one-hot vector, all-zero when en is low.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module onehot_decoder
    import bus_pkg::*;
#(
    parameter int SELW  = 2,
    parameter int NREGS = 4
) (
    input  logic [SELW-1:0]  sel,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    for (genvar i = 0; i < NREGS; i++) begin : g_bit
        assign onehot[i] = en && (sel == SELW'(i));
    end

endmodule
`default_nettype wire

// File: rtl/bus_transfer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_transfer_sequencer                                             |
// | Drives one-hot enables/loads for register transfers over two       |
// | tri-state buses and captures the bus values. BUS_TURNAROUND_EN     |
// | inserts a dead GAP cycle after every transfer.                     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bus_transfer_sequencer
    import bus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int SELW  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    output logic             ready,
    input  logic [SELW-1:0]  src1,
    input  logic [SELW-1:0]  src2,
    input  logic             use2,
    input  logic [SELW-1:0]  dst,
    input  logic             dst_en,
    input  logic [WIDTH-1:0] bus1,
    input  logic [WIDTH-1:0] bus2,
    output logic [NREGS-1:0] enable1,
    output logic [NREGS-1:0] enable2,
    output logic [NREGS-1:0] load,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic             done,
    output logic             err
);

    if ((SELW != clog2(NREGS)) || (NREGS < 2) || (NREGS > 16)) begin : g_param_check
        $error("bus_transfer_sequencer: SELW must equal clog2(NREGS), NREGS in 2..16");
    end

    localparam logic [SELW:0] c_nregs = (SELW + 1)'(NREGS);

    state_t             r_state;
    state_t             w_state_next;
    logic [SELW-1:0]    r_src1, r_src2, r_dst;
    logic               r_use2, r_dst_en;
    logic [SELW-1:0]    w_src1_next, w_src2_next, w_dst_next;
    logic               w_use2_next, w_dst_en_next;
    logic               w_valid, w_accept, w_reject;
    logic               w_drive_next, w_load_next;
    logic [NREGS-1:0]   w_enable1_next, w_enable2_next, w_load_vec_next;
    logic [NREGS-1:0]   r_enable1, r_enable2, r_load;
    logic [WIDTH-1:0]   r_rdata1, r_rdata2;
    logic               r_done, r_err;

    // Only selects that the transfer actually uses are range-checked.
    assign w_valid  = ({1'b0, src1} < c_nregs)
                   && (!use2   || ({1'b0, src2} < c_nregs))
                   && (!dst_en || ({1'b0, dst}  < c_nregs));
    assign w_accept = (r_state == IDLE) && req && w_valid;
    assign w_reject = (r_state == IDLE) && req && !w_valid;

    always_comb begin
        w_state_next  = r_state;
        w_src1_next   = r_src1;
        w_src2_next   = r_src2;
        w_dst_next    = r_dst;
        w_use2_next   = r_use2;
        w_dst_en_next = r_dst_en;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next  = DRIVE;
                    w_src1_next   = src1;
                    w_src2_next   = src2;
                    w_dst_next    = dst;
                    w_use2_next   = use2;
                    w_dst_en_next = dst_en;
                end
            end
            DRIVE:   w_state_next = CAPTURE;
`ifdef BUS_TURNAROUND_EN
            CAPTURE: w_state_next = GAP;
`else
            CAPTURE: w_state_next = IDLE;
`endif
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Enables are decoded from the next state so they register glitch-free.
    assign w_drive_next = (w_state_next == DRIVE) || (w_state_next == CAPTURE);
    assign w_load_next  = (w_state_next == CAPTURE) && w_dst_en_next;

    onehot_decoder #(.SELW(SELW), .NREGS(NREGS)) u_dec_enable1 (
        .sel    (w_src1_next),
        .en     (w_drive_next),
        .onehot (w_enable1_next)
    );

    onehot_decoder #(.SELW(SELW), .NREGS(NREGS)) u_dec_enable2 (
        .sel    (w_src2_next),
        .en     (w_drive_next && w_use2_next),
        .onehot (w_enable2_next)
    );

    onehot_decoder #(.SELW(SELW), .NREGS(NREGS)) u_dec_load (
        .sel    (w_dst_next),
        .en     (w_load_next),
        .onehot (w_load_vec_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_src1    <= '0;
            r_src2    <= '0;
            r_dst     <= '0;
            r_use2    <= 1'b0;
            r_dst_en  <= 1'b0;
            r_enable1 <= '0;
            r_enable2 <= '0;
            r_load    <= '0;
            r_rdata1  <= '0;
            r_rdata2  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_src1    <= w_src1_next;
            r_src2    <= w_src2_next;
            r_dst     <= w_dst_next;
            r_use2    <= w_use2_next;
            r_dst_en  <= w_dst_en_next;
            r_enable1 <= w_enable1_next;
            r_enable2 <= w_enable2_next;
            r_load    <= w_load_vec_next;
            r_done    <= (r_state == CAPTURE);
            r_err     <= w_reject;
            if (r_state == CAPTURE) begin
                r_rdata1 <= bus1;
                if (r_use2) begin
                    r_rdata2 <= bus2;
                end
            end
        end
    end

    assign ready   = (r_state == IDLE);
    assign enable1 = r_enable1;
    assign enable2 = r_enable2;
    assign load    = r_load;
    assign rdata1  = r_rdata1;
    assign rdata2  = r_rdata2;
    assign done    = r_done;
    assign err     = r_err;

endmodule
`default_nettype wire
